// File: rtl/piano_pkg.sv
// Shared definitions for the piano note path: note code width, rest code,
// sequencer states and the layout of the {note, duration} write word.
package piano_pkg;

  localparam int NOTE_W = 6;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  // The duration sits in the low bits; the note code sits directly above it.
  localparam int DUR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of {note, duration} words with exact occupancy count.
// SEQ_LOOP_EN: each popped word is re-pushed at the tail in the same cycle.
module note_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             loop_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty && !clear;
  // Acceptance uses the occupancy at the start of the cycle, so a pop never frees room for a same-cycle write.
  assign push_ok = push && !full && !clear;
  assign head    = mem[rd_ptr];

`ifdef SEQ_LOOP_EN
  assign loop_push = pop_ok;
`else
  assign loop_push = 1'b0;
`endif

  // NOTE: the storage array has no reset; only pointers and count need a defined start.
  always_ff @(posedge clk) begin
    if (loop_push) mem[wr_ptr] <= head;
    if (push_ok)   mem[wr_ptr + PTR_W'(loop_push)] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= wr_ptr + PTR_W'(loop_push) + PTR_W'(push_ok);
      count  <= count + CNT_W'(push_ok) - CNT_W'(pop_ok && !loop_push);
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued {note, duration} words on the beat tick, with a rest gap after
// each note. SEQ_LOOP_EN: the queue replays forever until cleared.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 1,
  parameter int DUR_W     = 8
) (
  input  logic                    iFpgaClock,
  input  logic                    iFpgaResetN,
  input  logic                    iBeatTick,
  input  logic                    iWrite,
  input  logic [NOTE_W+DUR_W-1:0] iWriteData,
  input  logic                    iPause,
  input  logic                    iClear,
  output logic [NOTE_W-1:0]       oTrack,
  output logic                    oBusy,
  output logic                    oEmpty,
  output logic                    oFull,
  output logic [$clog2(DEPTH):0]  oCount,
  output logic                    oOverflow
);

  localparam int WORD_W = NOTE_W + DUR_W;
  localparam int GAP_W  = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  seq_state_e        state;
  logic [NOTE_W-1:0] track_q;
  logic [DUR_W-1:0]  beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] head;
  logic [NOTE_W-1:0] head_note;
  logic [DUR_W-1:0]  head_dur;
  logic              tick;
  logic              note_end;
  logic              gap_end;
  logic              pop;

  note_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk       (iFpgaClock),
    .rst_n     (iFpgaResetN),
    .clear     (iClear),
    .push      (iWrite),
    .push_data (iWriteData),
    .pop       (pop),
    .head      (head),
    .count     (oCount),
    .empty     (oEmpty),
    .full      (oFull),
    .overflow  (oOverflow)
  );

  assign head_note = head[DUR_W +: NOTE_W];
  assign head_dur  = head[DUR_LSB +: DUR_W];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick     = iBeatTick && !iPause;
    note_end = 1'b0;
    gap_end  = 1'b0;
    if (state == PLAY) note_end = tick && (beat_cnt == DUR_W'(1));
    if (state == GAP)  gap_end  = tick && (gap_cnt == GAP_W'(1));
    pop = !oEmpty && !iPause && !iClear &&
          ((state == IDLE) || gap_end || (note_end && (GAP_TICKS == 0)));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iFpgaClock or negedge iFpgaResetN) begin
    if (!iFpgaResetN) begin
      state    <= IDLE;
      track_q  <= NOTE_REST;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else if (iClear) begin
      state    <= IDLE;
      track_q  <= NOTE_REST;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else if (pop) begin
      beat_cnt <= head_dur;
      if (head_dur != '0) begin
        state   <= PLAY;
        track_q <= head_note;
      end else begin
        // A zero-length note skips straight to its articulation gap.
        state   <= (GAP_TICKS > 0) ? GAP : IDLE;
        gap_cnt <= GAP_W'(GAP_TICKS);
        track_q <= NOTE_REST;
      end
    end else begin
      case (state)
        PLAY: if (tick) begin
          if (note_end) begin
            state   <= (GAP_TICKS > 0) ? GAP : IDLE;
            gap_cnt <= GAP_W'(GAP_TICKS);
            track_q <= NOTE_REST;
          end else begin
            beat_cnt <= beat_cnt - DUR_W'(1);
          end
        end
        GAP: if (tick) begin
          if (gap_end) state <= IDLE;
          else         gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pause silences the output at once while the held note keeps its remaining beats.
  assign oTrack = iPause ? NOTE_REST : track_q;
  assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a cycle table for plain playback plus
// hand sequences for overflow, clear, pause and the SEQ_LOOP_EN replay.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iBeatTick = 1'b0;
  logic        iWrite = 1'b0;
  logic [13:0] iWriteData = '0;
  logic        iPause = 1'b0;
  logic        iClear = 1'b0;
  logic [5:0]  oTrack;
  logic        oBusy;
  logic        oEmpty;
  logic        oFull;
  logic [4:0]  oCount;
  logic        oOverflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(16), .GAP_TICKS(1), .DUR_W(8)) dut (
    .iFpgaClock  (clk),
    .iFpgaResetN (rst_n),
    .iBeatTick   (iBeatTick),
    .iWrite      (iWrite),
    .iWriteData  (iWriteData),
    .iPause      (iPause),
    .iClear      (iClear),
    .oTrack      (oTrack),
    .oBusy       (oBusy),
    .oEmpty      (oEmpty),
    .oFull       (oFull),
    .oCount      (oCount),
    .oOverflow   (oOverflow)
  );

  typedef struct {
    string name;
    logic  wr;
    int    note;
    int    dur;
    logic  tk;
    logic  ps;
    int    exp_track;
    int    exp_busy;
    int    exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic wr, int note, int dur, logic tk, logic ps,
                              int exp_track, int exp_busy, int exp_count);
    vec_t v;
    v.name = name; v.wr = wr; v.note = note; v.dur = dur; v.tk = tk; v.ps = ps;
    v.exp_track = exp_track; v.exp_busy = exp_busy; v.exp_count = exp_count;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then settle just after the edge.
  task automatic apply(input logic wr, input int note, input int dur,
                       input logic tk, input logic ps, input logic cl);
    @(negedge clk);
    iWrite     = wr;
    iWriteData = {6'(note), 8'(dur)};
    iBeatTick  = tk;
    iPause     = ps;
    iClear     = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: {5,3} -> note two cycles after the write, 3 beats, 1 gap beat.
    vecs.push_back(mk("t1_write",  1, 5, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t1_start",  0, 0, 0, 0, 0, 5, 1, 0));
    vecs.push_back(mk("t1_beat1",  0, 0, 0, 1, 0, 5, 1, 0));
    vecs.push_back(mk("t1_hold",   0, 0, 0, 0, 0, 5, 1, 0));
    vecs.push_back(mk("t1_beat2",  0, 0, 0, 1, 0, 5, 1, 0));
    vecs.push_back(mk("t1_beat3",  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("t1_gap",    0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t1_idle",   0, 0, 0, 1, 0, 0, 0, 0));
    // Test 2: two {7,2} queued while paused, then played 7,7,0,7,7,0.
    vecs.push_back(mk("t2_wr_a",   1, 7, 2, 0, 1, 0, 0, 1));
    vecs.push_back(mk("t2_wr_b",   1, 7, 2, 0, 1, 0, 0, 2));
    vecs.push_back(mk("t2_pop_a",  0, 0, 0, 0, 0, 7, 1, 1));
    vecs.push_back(mk("t2_a_b1",   0, 0, 0, 1, 0, 7, 1, 1));
    vecs.push_back(mk("t2_a_b2",   0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("t2_pop_b",  0, 0, 0, 1, 0, 7, 1, 0));
    vecs.push_back(mk("t2_b_b1",   0, 0, 0, 1, 0, 7, 1, 0));
    vecs.push_back(mk("t2_b_b2",   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("t2_idle",   0, 0, 0, 1, 0, 0, 0, 0));
    // Test 5: {3,0} gives only a gap beat, then {4,1} plays one beat.
    vecs.push_back(mk("t5_wr_3",   1, 3, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t5_gap3",   1, 4, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("t5_play4",  0, 0, 0, 1, 0, 4, 1, 0));
    vecs.push_back(mk("t5_gap4",   0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("t5_idle",   0, 0, 0, 1, 0, 0, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_track", oTrack, 0);
    check("rst_busy", oBusy, 0);
    check("rst_empty", oEmpty, 1);
    check("rst_full", oFull, 0);
    check("rst_count", oCount, 0);
    check("rst_overflow", oOverflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef SEQ_LOOP_EN
    foreach (vecs[i]) begin
      apply(vecs[i].wr, vecs[i].note, vecs[i].dur, vecs[i].tk, vecs[i].ps, 1'b0);
      check({vecs[i].name, "_track"}, oTrack, vecs[i].exp_track);
      check({vecs[i].name, "_busy"}, oBusy, vecs[i].exp_busy);
      check({vecs[i].name, "_count"}, oCount, vecs[i].exp_count);
    end

    // Test 4: {9,4} with a 5-tick pause after beat 2.
    apply(1, 9, 4, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    check("t4_start", oTrack, 9);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_after_b2", oTrack, 9);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 1, 1, 0);
      check("t4_paused_track", oTrack, 0);
      check("t4_paused_busy", oBusy, 1);
    end
    apply(0, 0, 0, 0, 0, 0);
    check("t4_resume", oTrack, 9);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_after_b3", oTrack, 9);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_after_b4", oTrack, 0);
    check("t4_gap_busy", oBusy, 1);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_idle", oBusy, 0);
`endif

    // Test 3: fill to DEPTH while paused, overflow on the 17th, then clear.
    apply(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      apply(1, i + 1, 2, 0, 1, 0);
      if (i == 14) check("t3_not_full_15", oFull, 0);
    end
    check("t3_count16", oCount, 16);
    check("t3_full", oFull, 1);
    check("t3_no_ovf_yet", oOverflow, 0);
    apply(1, 20, 2, 0, 1, 0);
    check("t3_count_held", oCount, 16);
    check("t3_ovf", oOverflow, 1);
    apply(1, 21, 2, 0, 1, 1);
    check("t3_clr_count", oCount, 0);
    check("t3_clr_ovf", oOverflow, 0);
    check("t3_clr_empty", oEmpty, 1);
    apply(0, 0, 0, 0, 0, 0);
    check("t3_clr_wr_dropped", oCount, 0);
    check("t3_clr_wr_no_ovf", oOverflow, 0);
    check("t3_clr_idle", oBusy, 0);

`ifdef SEQ_LOOP_EN
    // Test 6: {1,1},{2,1} replay 1,0,2,0,... with occupancy fixed at 2.
    apply(1, 1, 1, 0, 1, 0);
    apply(1, 2, 1, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int exp_t;
      case (i % 4)
        0: exp_t = 1;
        2: exp_t = 2;
        default: exp_t = 0;
      endcase
      check("t6_track", oTrack, exp_t);
      check("t6_count", oCount, 2);
      apply(0, 0, 0, 1, 0, 0);
    end
    apply(0, 0, 0, 0, 0, 1);
    check("t6_clear", oCount, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
